pipelined_cla_addsub: RTL and testbench

- Parametrised, two-stage pipelined carry-lookahead adder/subtractor.
- Computes a+b+cin, or a−b, on WIDTH-bit operands using GROUP-bit lookahead blocks plus a second group-level lookahead.
- Valid/ready handshake on both sides; sits on datapath buses where the 4-bit combinational adder is too narrow and too slow.
- Sustains one result per clock when downstream is ready.

---
 rtl/pipelined_cla_addsub_if.sv | 28 ++
 rtl/pipelined_cla_addsub.sv | 136 +++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_addsub_if.sv
// Valid/ready operand and result bundle for the
// pipelined carry-lookahead adder/subtractor.
interface pipelined_cla_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Two-stage carry-lookahead add/sub: stage 1 forms bit and
// group propagate/generate, stage 2 resolves carries and flags.
module pipelined_cla_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipelined_cla_addsub_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  if (WIDTH <= 0 || GROUP <= 0 || (WIDTH % GROUP) != 0)
  begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of GROUP");
  end

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    gp;
    logic [NG-1:0]    gg;
    logic             c0;
    logic             a_msb;
    logic             bb_msb;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;
  } s2_t;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d, s1_n;
  s2_t  s2_q, s2_d, s2_n;
  logic adv1, adv2;

  always_comb begin : s1_logic
    logic [WIDTH-1:0] bb;
    logic t;
    t  = 1'b0;
    bb = bus.b ^ {WIDTH{bus.sub}};
    s1_n        = '0;
    s1_n.p      = bus.a ^ bb;
    s1_n.g      = bus.a & bb;
    s1_n.c0     = bus.sub | bus.cin;
    s1_n.a_msb  = bus.a[WIDTH-1];
    s1_n.bb_msb = bb[WIDTH-1];
    for (int k = 0; k < NG; k++) begin
      s1_n.gp[k] = &s1_n.p[k*GROUP +: GROUP];
      // Flat sum-of-products group generate.
      for (int i = 0; i < GROUP; i++) begin
        t = s1_n.g[k*GROUP+i];
        for (int j = i + 1; j < GROUP; j++)
          t = t & s1_n.p[k*GROUP+j];
        s1_n.gg[k] = s1_n.gg[k] | t;
      end
    end
  end

  always_comb begin : s2_logic
    logic [NG:0]      cg;
    logic [WIDTH-1:0] cb;
    logic t, c;
    t     = 1'b0;
    c     = 1'b0;
    cb    = '0;
    cg    = '0;
    cg[0] = s1_q.c0;
    // Group carries expanded flat, no ripple between groups.
    for (int k = 0; k < NG; k++) begin
      c = s1_q.c0;
      for (int m = 0; m <= k; m++)
        c = c & s1_q.gp[m];
      for (int m = 0; m <= k; m++) begin
        t = s1_q.gg[m];
        for (int j = m + 1; j <= k; j++)
          t = t & s1_q.gp[j];
        c = c | t;
      end
      cg[k+1] = c;
    end
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        c = cg[k];
        for (int j = 0; j < i; j++)
          c = c & s1_q.p[k*GROUP+j];
        for (int j = 0; j < i; j++) begin
          t = s1_q.g[k*GROUP+j];
          for (int l = j + 1; l < i; l++)
            t = t & s1_q.p[k*GROUP+l];
          c = c | t;
        end
        cb[k*GROUP+i] = c;
      end
    end
    s2_n.s    = s1_q.p ^ cb;
    s2_n.cout = cg[NG];
    s2_n.ovf  = (s1_q.a_msb == s1_q.bb_msb) &
                (s2_n.s[WIDTH-1] != s1_q.a_msb);
    s2_n.zero = ~|s2_n.s;
  end

  always_comb begin
    adv2       = !s2_valid_q | bus.out_ready;
    adv1       = !s1_valid_q | adv2;
    s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
    s1_d       = (adv1 && bus.in_valid) ? s1_n : s1_q;
    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    s2_d       = (adv2 && s1_valid_q) ? s2_n : s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.s         = s2_q.s;
  assign bus.cout      = s2_q.cout;
  assign bus.ovf       = s2_q.ovf;
  assign bus.zero      = s2_q.zero;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub at 16/4, 8/4 and 32/8 with
// directed vectors and a queue-based arithmetic reference.
module tb_pipelined_cla_addsub;
  logic clk = 1'b0;
  logic rst, rst16;

  always #5 clk = ~clk;

  pipelined_cla_addsub_if #(.WIDTH(16)) i16 ();
  pipelined_cla_addsub_if #(.WIDTH(8))  i8 ();
  pipelined_cla_addsub_if #(.WIDTH(32)) i32 ();

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) u16 (
    .clk(clk), .rst(rst16), .bus(i16)
  );
  pipelined_cla_addsub #(.WIDTH(8), .GROUP(4)) u8 (
    .clk(clk), .rst(rst), .bus(i8)
  );
  pipelined_cla_addsub #(.WIDTH(32), .GROUP(8)) u32 (
    .clk(clk), .rst(rst), .bus(i32)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  res_t q16[$], q8[$], q32[$];
  vec_t tbl[10];
  logic [15:0] bpa[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] bpb[4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};

  // Reference: plain modular and signed-range arithmetic.
  function automatic res_t model(input int w,
    input logic [31:0] a, input logic [31:0] b,
    input logic cin, input logic sub);
    longint m, ua, ub, sa, sb, u, sg;
    res_t r;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      u  = ua - ub + m;
      sg = sa - sb;
    end else begin
      u  = ua + ub + longint'(cin);
      sg = sa + sb + longint'(cin);
    end
    r.s    = 32'(u % m);
    r.cout = (u >= m);
    r.ovf  = (sg >= m / 2) || (sg < -(m / 2));
    r.zero = ((u % m) == 0);
    return r;
  endfunction

  task automatic chk(input string nm,
    input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic sb_check(input string nm, input res_t got,
    input int sz, input res_t exp);
    vectors++;
    if (sz == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected output s=%h, none pending",
        nm, got.s);
    end else if (got !== exp) begin
      miscompares++;
      $display({"FAIL %s: got s=%h c=%b v=%b z=%b,",
        " expected s=%h c=%b v=%b z=%b"}, nm,
        got.s, got.cout, got.ovf, got.zero,
        exp.s, exp.cout, exp.ovf, exp.zero);
    end
  endtask

  always @(negedge clk) begin : sb
    res_t got, exp;
    int sz;
    if (rst16) q16.delete();
    else begin
      if (i16.out_valid && i16.out_ready) begin
        got = {16'h0, i16.s, i16.cout, i16.ovf, i16.zero};
        sz = q16.size(); exp = '0;
        if (sz > 0) exp = q16.pop_front();
        sb_check("sb16", got, sz, exp);
      end
      if (i16.in_valid && i16.in_ready)
        q16.push_back(model(16, 32'(i16.a), 32'(i16.b),
          i16.cin, i16.sub));
    end
    if (rst) begin
      q8.delete();
      q32.delete();
    end else begin
      if (i8.out_valid && i8.out_ready) begin
        got = {24'h0, i8.s, i8.cout, i8.ovf, i8.zero};
        sz = q8.size(); exp = '0;
        if (sz > 0) exp = q8.pop_front();
        sb_check("sb8", got, sz, exp);
      end
      if (i8.in_valid && i8.in_ready)
        q8.push_back(model(8, 32'(i8.a), 32'(i8.b),
          i8.cin, i8.sub));
      if (i32.out_valid && i32.out_ready) begin
        got = {i32.s, i32.cout, i32.ovf, i32.zero};
        sz = q32.size(); exp = '0;
        if (sz > 0) exp = q32.pop_front();
        sb_check("sb32", got, sz, exp);
      end
      if (i32.in_valid && i32.in_ready)
        q32.push_back(model(32, i32.a, i32.b,
          i32.cin, i32.sub));
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push16(input logic [15:0] a,
    input logic [15:0] b, input logic cin,
    input logic sub, input bit rnd);
    int n;
    n = 0;
    i16.a = a; i16.b = b;
    i16.cin = cin; i16.sub = sub;
    i16.in_valid = 1'b1;
    if (rnd) i16.out_ready = 1'($urandom);
    #1;
    while (!i16.in_ready && n < 200) begin
      step;
      if (rnd) i16.out_ready = 1'($urandom);
      #1;
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL push16_timeout: in_ready low %0d cycles", n);
    end
    step;
    i16.in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    nm = $sformatf("vec%0d", idx);
    push16(v.a, v.b, v.cin, v.sub, 1'b0);
    chk({nm, "_lat"}, 32'(i16.out_valid), 32'h0);
    step;
    chk({nm, "_valid"}, 32'(i16.out_valid), 32'h1);
    chk({nm, "_s"}, 32'(i16.s), 32'(v.s));
    chk({nm, "_cout"}, 32'(i16.cout), 32'(v.cout));
    chk({nm, "_ovf"}, 32'(i16.ovf), 32'(v.ovf));
    chk({nm, "_zero"}, 32'(i16.zero), 32'(v.zero));
    step;
    step;
  endtask

  task automatic test16;
    logic [15:0] hold;
    res_t        r;
    bit          acc, seen;
    int          idx;
    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    for (int n = 0; n < 100; n++) begin
      i16.a = 16'($urandom); i16.b = 16'($urandom);
      i16.cin = 1'($urandom); i16.sub = 1'($urandom);
      i16.in_valid = 1'b1;
      chk("stream_rdy", 32'(i16.in_ready), 32'h1);
      if (n >= 2)
        chk("stream_ov", 32'(i16.out_valid), 32'h1);
      step;
    end
    i16.in_valid = 1'b0;
    repeat (4) step;
    chk("stream_drain", 32'(q16.size()), 32'h0);

    i16.out_ready = 1'b0;
    idx = 0; seen = 0; hold = '0;
    for (int c = 0; c < 5; c++) begin
      i16.a = bpa[idx]; i16.b = bpb[idx];
      i16.cin = 1'b0; i16.sub = 1'b0;
      i16.in_valid = 1'b1;
      #1;
      acc = i16.in_ready;
      if (i16.out_valid) begin
        if (!seen) begin hold = i16.s; seen = 1; end
        else chk("bp_frozen", 32'(i16.s), 32'(hold));
      end
      step;
      if (acc && idx < 3) idx++;
    end
    r = model(16, 32'(bpa[0]), 32'(bpb[0]), 1'b0, 1'b0);
    chk("bp_accepted", 32'(idx), 32'h2);
    chk("bp_in_ready", 32'(i16.in_ready), 32'h0);
    chk("bp_out_valid", 32'(i16.out_valid), 32'h1);
    chk("bp_head", 32'(i16.s), r.s);
    i16.out_ready = 1'b1;
    push16(bpa[2], bpb[2], 1'b0, 1'b0, 1'b0);
    push16(bpa[3], bpb[3], 1'b0, 1'b0, 1'b0);
    repeat (4) step;
    chk("bp_drain", 32'(q16.size()), 32'h0);

    for (int n = 0; n < 150; n++)
      push16(16'($urandom), 16'($urandom),
        1'($urandom), 1'($urandom), 1'b1);
    i16.out_ready = 1'b1;
    repeat (4) step;
    chk("rnd_drain", 32'(q16.size()), 32'h0);

    push16(16'h1000, 16'h0001, 1'b0, 1'b0, 1'b0);
    push16(16'h2000, 16'h0002, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", 32'(i16.out_valid), 32'h1);
    #2 rst16 = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(i16.out_valid), 32'h0);
    chk("mid_rst_s", 32'(i16.s), 32'h0);
    chk("mid_rst_cout", 32'(i16.cout), 32'h0);
    chk("mid_rst_ovf", 32'(i16.ovf), 32'h0);
    chk("mid_rst_zero", 32'(i16.zero), 32'h0);
    step;
    step;
    rst16 = 1'b0;
    #1;
    chk("post_rst_ready", 32'(i16.in_ready), 32'h1);
    repeat (3) begin
      step;
      chk("no_stale", 32'(i16.out_valid), 32'h0);
    end
    push16(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
    chk("post_rst_lat", 32'(i16.out_valid), 32'h0);
    step;
    chk("post_rst_valid", 32'(i16.out_valid), 32'h1);
    chk("post_rst_s", 32'(i16.s), 32'h2345);
    repeat (3) step;
  endtask

  task automatic test8;
    i8.a = 8'hFF; i8.b = 8'h01;
    i8.cin = 1'b0; i8.sub = 1'b0;
    i8.in_valid = 1'b1;
    step;
    for (int i = 0; i < 65536; i++) begin
      i8.a   = i[7:0];
      i8.b   = i[15:8];
      i8.sub = i[0] ^ i[8] ^ i[5] ^ i[13];
      i8.cin = 1'($urandom);
      step;
    end
    i8.in_valid = 1'b0;
    repeat (4) step;
  endtask

  task automatic test32;
    i32.a = 32'hFFFF_FFFF; i32.b = 32'h1;
    i32.cin = 1'b0; i32.sub = 1'b0;
    i32.in_valid = 1'b1;
    step;
    for (int n = 0; n < 100; n++) begin
      i32.a = $urandom; i32.b = $urandom;
      i32.cin = 1'($urandom); i32.sub = 1'($urandom);
      step;
    end
    i32.in_valid = 1'b0;
    repeat (4) step;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 16'hFFFF, 16'h0001,
               16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b0, 16'h7FFF, 16'h0001,
               16'h8000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h00FF, 16'h0000,
               16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0005, 16'h0007,
               16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h8000, 16'h0001,
               16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h0005, 16'h0007,
               16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16'h8000, 16'h0001,
               16'h7FFF, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h1234, 16'h1234,
               16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 16'h0FFF, 16'h0001,
               16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 16'h8000, 16'h8000,
               16'h0000, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; rst16 = 1'b1;
    i16.in_valid = 1'b0; i16.out_ready = 1'b1;
    i16.a = '0; i16.b = '0; i16.cin = 1'b0; i16.sub = 1'b0;
    i8.in_valid = 1'b0; i8.out_ready = 1'b1;
    i8.a = '0; i8.b = '0; i8.cin = 1'b0; i8.sub = 1'b0;
    i32.in_valid = 1'b0; i32.out_ready = 1'b1;
    i32.a = '0; i32.b = '0; i32.cin = 1'b0; i32.sub = 1'b0;
    step;
    step;
    chk("rst_valid16", 32'(i16.out_valid), 32'h0);
    chk("rst_s16", 32'(i16.s), 32'h0);
    chk("rst_cout16", 32'(i16.cout), 32'h0);
    chk("rst_ovf16", 32'(i16.ovf), 32'h0);
    chk("rst_zero16", 32'(i16.zero), 32'h0);
    chk("rst_valid8", 32'(i8.out_valid), 32'h0);
    chk("rst_valid32", 32'(i32.out_valid), 32'h0);
    rst = 1'b0; rst16 = 1'b0;
    #1;
    chk("rel_ready16", 32'(i16.in_ready), 32'h1);
    chk("rel_ready8", 32'(i8.in_ready), 32'h1);
    chk("rel_ready32", 32'(i32.in_ready), 32'h1);

    fork
      test16;
      test8;
      test32;
    join

    chk("q16_left", 32'(q16.size()), 32'h0);
    chk("q8_left", 32'(q8.size()), 32'h0);
    chk("q32_left", 32'(q32.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end
endmodule
